mmult_opt_mdc_out_tracker: RTL and testbench

- Sits on the out_r result stream, between the mmult_opt_mdc engine output and the streamer sink.
- Forwards beats through a 2-entry registered skid buffer and counts handshakes against the job's cnt_limit_out_r.
- Marks the final beat, pulses done when the job's last beat leaves, and flags overruns and stalls back to the FSM.
- The FSM drives start/limit/clear; the flags feed the FSM's end-of-job decision.

---
 rtl/mmult_opt_mdc_package.sv | 31 +++
 rtl/mmult_opt_mdc_out_tracker_if.sv | 12 +
 rtl/mmult_opt_mdc_skid_buf.sv | 62 ++++++
 rtl/mmult_opt_mdc_out_tracker.sv | 142 ++++++++++++++
 tb/tb_mmult_opt_mdc_out_tracker.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmult_opt_mdc_package.sv
// rtl/mmult_opt_mdc_package.sv - shared types for the mmult_opt_mdc out_r stream tracker
package mmult_opt_mdc_package;

    localparam int OT_CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        OT_IDLE,
        OT_RUN,
        OT_DRAIN,
        OT_DONE
    } out_tracker_state_t;

    typedef struct packed {
        logic                    start;
        logic                    clear;
        logic [OT_CNT_WIDTH-1:0] cnt_limit;
    } ctrl_out_tracker_t;

    typedef struct packed {
        logic                    busy;
        logic                    done;
        logic [OT_CNT_WIDTH-1:0] cnt;
        logic                    err_overrun;
        logic                    timeout;
    } flags_out_tracker_t;

    function automatic logic is_busy_state(input out_tracker_state_t s);
        return (s == OT_RUN) || (s == OT_DRAIN);
    endfunction

endpackage

// File: rtl/mmult_opt_mdc_out_tracker_if.sv
// rtl/mmult_opt_mdc_out_tracker_if.sv - valid/ready beat stream carrying data and byte strobe
interface mmult_opt_mdc_out_tracker_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport master (output valid, data, strb, input ready);
    modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/mmult_opt_mdc_skid_buf.sv
// rtl/mmult_opt_mdc_skid_buf.sv - 2-entry registered FIFO of {data, strb, last}
module mmult_opt_mdc_skid_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    input  logic [DATA_WIDTH/8-1:0] in_strb_i,
    input  logic                    in_last_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic [DATA_WIDTH/8-1:0] out_strb_o,
    output logic                    out_last_o,
    output logic [1:0]              occ_o
);
    localparam int W = DATA_WIDTH + DATA_WIDTH/8 + 1;

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic         push;
    logic         pop;
    logic         last_raw;

    assign in_ready_o  = (occ_o != 2'd2);
    assign out_valid_o = (occ_o != 2'd0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    assign {out_data_o, out_strb_o, last_raw} = mem_q[rd_ptr_q];
    // Stale entries keep their last bit; only a live head may report it.
    assign out_last_o = last_raw && out_valid_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_o    <= 2'd0;
        end else if (clear_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_o    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {in_data_i, in_strb_i, in_last_i};
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            occ_o <= occ_o + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/mmult_opt_mdc_out_tracker.sv
// rtl/mmult_opt_mdc_out_tracker.sv - out_r beat forwarder with job counting, done, overrun and stall flags
module mmult_opt_mdc_out_tracker
    import mmult_opt_mdc_package::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int WDOG_CYCLES = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           start_i,
    input  logic [CNT_WIDTH-1:0]           cnt_limit_i,
    mmult_opt_mdc_out_tracker_if.slave     in_s,
    mmult_opt_mdc_out_tracker_if.master    out_m,
    output logic                           out_last_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [CNT_WIDTH-1:0]           cnt_o,
    output logic                           err_overrun_o,
    output logic                           timeout_o
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] WDOG_LIM = CNT_WIDTH'(WDOG_CYCLES);

    out_tracker_state_t      state_q;
    logic [CNT_WIDTH-1:0]    limit_q;
    logic [CNT_WIDTH-1:0]    in_cnt_q;
    logic [CNT_WIDTH-1:0]    wdog_q;
    logic [1:0]              occ;
    logic                    buf_in_ready;
    logic                    buf_out_valid;
    logic [DATA_WIDTH-1:0]   buf_data;
    logic [DATA_WIDTH/8-1:0] buf_strb;
    logic                    push;
    logic                    pop;
    logic                    in_last;
    logic                    stall;

    assign in_s.ready = (state_q == OT_RUN) && buf_in_ready && (in_cnt_q < limit_q);
    assign push       = in_s.valid && in_s.ready;
    assign pop        = buf_out_valid && out_m.ready;
    assign in_last    = (in_cnt_q == limit_q - CNT_ONE);

    assign out_m.valid = buf_out_valid;
    assign out_m.data  = buf_data;
    assign out_m.strb  = buf_strb;

    assign busy_o = is_busy_state(state_q);
    assign done_o = (state_q == OT_DONE);
    assign stall  = busy_o && buf_out_valid && !out_m.ready;

    mmult_opt_mdc_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid_buf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_valid_i  (push),
        .in_ready_o  (buf_in_ready),
        .in_data_i   (in_s.data),
        .in_strb_i   (in_s.strb),
        .in_last_i   (in_last),
        .out_valid_o (buf_out_valid),
        .out_ready_i (out_m.ready),
        .out_data_o  (buf_data),
        .out_strb_o  (buf_strb),
        .out_last_o  (out_last_o),
        .occ_o       (occ)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= OT_IDLE;
            limit_q       <= '0;
            in_cnt_q      <= '0;
            cnt_o         <= '0;
            wdog_q        <= '0;
            err_overrun_o <= 1'b0;
            timeout_o     <= 1'b0;
        end else if (clear_i) begin
            state_q       <= OT_IDLE;
            limit_q       <= '0;
            in_cnt_q      <= '0;
            cnt_o         <= '0;
            wdog_q        <= '0;
            err_overrun_o <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            if (push && (in_cnt_q != limit_q)) begin
                in_cnt_q <= in_cnt_q + CNT_ONE;
            end
            if (pop && (cnt_o != limit_q)) begin
                cnt_o <= cnt_o + CNT_ONE;
            end
            if (in_s.valid && (state_q != OT_RUN)) begin
                err_overrun_o <= 1'b1;
            end

            if (pop || !busy_o) begin
                wdog_q <= '0;
            end else if (stall && (wdog_q != WDOG_LIM)) begin
                wdog_q <= wdog_q + CNT_ONE;
            end
            // Fires on the stalled cycle that brings the count to the threshold.
            if ((WDOG_CYCLES != 0) && stall && (wdog_q + CNT_ONE == WDOG_LIM)) begin
                timeout_o <= 1'b1;
            end

            case (state_q)
                OT_IDLE: begin
                    if (start_i) begin
                        limit_q       <= cnt_limit_i;
                        in_cnt_q      <= '0;
                        cnt_o         <= '0;
                        wdog_q        <= '0;
                        err_overrun_o <= 1'b0;
                        timeout_o     <= 1'b0;
                        state_q       <= (cnt_limit_i != '0) ? OT_RUN : OT_DONE;
                    end
                end
                OT_RUN: begin
                    if (push && (in_cnt_q + CNT_ONE == limit_q)) begin
                        state_q <= OT_DRAIN;
                    end
                end
                OT_DRAIN: begin
                    // Post-pop view so done trails the final output handshake by one cycle.
                    if ((occ == {1'b0, pop}) && (cnt_o + CNT_WIDTH'(pop) == limit_q)) begin
                        state_q <= OT_DONE;
                    end
                end
                OT_DONE: begin
                    state_q <= OT_IDLE;
                end
                default: begin
                    state_q <= OT_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmult_opt_mdc_out_tracker.sv
// tb/tb_mmult_opt_mdc_out_tracker.sv - randomized scoreboard bench for mmult_opt_mdc_out_tracker
module tb_mmult_opt_mdc_out_tracker;
    localparam int DW   = 32;
    localparam int CW   = 32;
    localparam int WDOG = 16;

    logic          clk_i       = 1'b0;
    logic          rst_ni      = 1'b0;
    logic          clear_i     = 1'b0;
    logic          start_i     = 1'b0;
    logic [CW-1:0] cnt_limit_i = '0;
    logic          out_last_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] cnt_o;
    logic          err_overrun_o;
    logic          timeout_o;

    mmult_opt_mdc_out_tracker_if #(.DATA_WIDTH(DW)) in_if ();
    mmult_opt_mdc_out_tracker_if #(.DATA_WIDTH(DW)) out_if ();

    mmult_opt_mdc_out_tracker #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .cnt_limit_i  (cnt_limit_i),
        .in_s         (in_if),
        .out_m        (out_if),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .cnt_o        (cnt_o),
        .err_overrun_o(err_overrun_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0]   d;
        logic [DW/8-1:0] s;
        logic            l;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    done_seen = 0;

    // Job-level reference: counts of accepted/delivered beats, not RTL state.
    int    m_limit = 0, m_acc = 0, m_del = 0, m_stall = 0;
    bit    m_active = 0, m_done = 0, m_err = 0, m_to = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_limit = 0; m_acc = 0; m_del = 0; m_stall = 0;
        m_active = 0; m_done = 0; m_err = 0; m_to = 0;
    endtask

    // Monitor / scoreboard
    initial begin
        beat_t b;
        bit    run_now, busy_now, done_now, push, pop;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                model_reset();
            end else begin
                busy_now = m_active;
                run_now  = m_active && (m_acc < m_limit);
                done_now = m_done;
                chk("busy", busy_o, busy_now);
                chk("in_ready", in_if.ready, run_now && (exp_q.size() < 2));
                chk("out_valid", out_if.valid, exp_q.size() != 0);
                chk("done", done_o, done_now);
                chk("cnt", cnt_o, m_del);
                chk("overrun", err_overrun_o, m_err);
                chk("timeout", timeout_o, m_to);
                if (exp_q.size() != 0) begin
                    chk("out_data", out_if.data, exp_q[0].d);
                    chk("out_strb", out_if.strb, exp_q[0].s);
                    chk("out_last", out_last_o, exp_q[0].l);
                end else begin
                    chk("last_idle", out_last_o, 1'b0);
                end
                if (done_o) done_seen++;

                push   = in_if.valid && in_if.ready;
                pop    = out_if.valid && out_if.ready;
                m_done = 0;
                if (clear_i) begin
                    model_reset();
                end else begin
                    if (in_if.valid && !run_now) m_err = 1;
                    if (push) begin
                        b.d = in_if.data;
                        b.s = in_if.strb;
                        b.l = (m_acc == m_limit - 1);
                        exp_q.push_back(b);
                        m_acc++;
                    end
                    if (pop) begin
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        m_del++;
                        if (m_del == m_limit) begin
                            m_active = 0;
                            m_done   = 1;
                        end
                    end
                    if (!busy_now || pop) begin
                        m_stall = 0;
                    end else if (out_if.valid && !out_if.ready) begin
                        m_stall++;
                        if (m_stall == WDOG) m_to = 1;
                    end
                    if (start_i && !busy_now && !done_now) begin
                        m_limit = int'(cnt_limit_i);
                        m_acc = 0; m_del = 0; m_stall = 0;
                        m_err = 0; m_to = 0;
                        if (m_limit != 0) m_active = 1;
                        else m_done = 1;
                    end
                end
            end
        end
    end

    // rmode: 0 ready high, 1 toggling, 2 random, 3 low for 24 cycles then high
    task automatic run_job(input int limit, input int vprob, input int rmode,
                           input bit extra, input int clr_after, input int exp_done);
        int sent, cyc, extra_left;
        bit took;
        @(posedge clk_i); #1;
        done_seen   = 0;
        start_i     = 1'b1;
        cnt_limit_i = CW'(limit);
        in_if.valid = 1'b0;
        out_if.ready = 1'b1;
        @(posedge clk_i); #1;
        start_i     = 1'b0;
        cnt_limit_i = $urandom;
        sent = 0; cyc = 0; took = 0;
        extra_left = extra ? 2 : 0;
        while (1) begin
            if (took) begin
                sent++;
                in_if.valid = 1'b0;
            end
            case (rmode)
                0:       out_if.ready = 1'b1;
                1:       out_if.ready = (cyc % 2 == 0);
                2:       out_if.ready = 1'($urandom_range(1));
                default: out_if.ready = (cyc >= 24);
            endcase
            if (clr_after >= 0 && sent == clr_after) begin
                clear_i     = 1'b1;
                in_if.valid = 1'b0;
                @(posedge clk_i); #1;
                clear_i = 1'b0;
                break;
            end
            if (sent < limit) begin
                if (!in_if.valid && ($urandom_range(99) < vprob)) begin
                    in_if.valid = 1'b1;
                    in_if.data  = $urandom;
                    in_if.strb  = 4'($urandom);
                end
            end else if (extra_left > 0) begin
                in_if.valid = 1'b1;
                in_if.data  = $urandom;
                extra_left--;
            end else begin
                in_if.valid = 1'b0;
            end
            #3;
            took = in_if.valid && in_if.ready;
            cyc++;
            if (done_seen != 0 || cyc >= 300) break;
            @(posedge clk_i); #1;
        end
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        if (clr_after < 0) chk("job_complete", done_seen != 0, 1'b1);
        repeat (3) @(posedge clk_i);
        #1;
        chk("done_pulses", done_seen, exp_done);
    endtask

    initial begin
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.strb   = '0;
        out_if.ready = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", out_if.valid, 1'b0);
        chk("rst_ready", in_if.ready, 1'b0);
        chk("rst_data", out_if.data, 0);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);

        run_job(4, 100, 0, 0, -1, 1);
        run_job(8, 100, 1, 0, -1, 1);
        run_job(3, 100, 0, 1, -1, 1);
        chk("t3_overrun", err_overrun_o, 1'b1);
        chk("t3_cnt", cnt_o, 3);
        run_job(0, 0, 0, 0, -1, 1);
        run_job(2, 100, 3, 0, -1, 1);
        chk("t5_timeout", timeout_o, 1'b1);
        chk("t5_cnt", cnt_o, 2);
        run_job(5, 100, 0, 0, 2, 0);
        run_job(1, 100, 0, 0, -1, 1);
        chk("t6_cnt", cnt_o, 1);
        for (int j = 0; j < 20; j++) begin
            run_job(int'($urandom_range(1, 10)), int'($urandom_range(30, 100)), 2,
                    1'($urandom_range(1)), -1, 1);
        end

        // Asynchronous reset in the middle of a job abandons it silently.
        @(posedge clk_i); #1;
        done_seen   = 0;
        start_i     = 1'b1;
        cnt_limit_i = CW'(5);
        @(posedge clk_i); #1;
        start_i      = 1'b0;
        in_if.valid  = 1'b1;
        in_if.data   = $urandom;
        out_if.ready = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        rst_ni      = 1'b0;
        in_if.valid = 1'b0;
        #1;
        chk("arst_valid", out_if.valid, 1'b0);
        chk("arst_cnt", cnt_o, 0);
        #5;
        rst_ni       = 1'b1;
        out_if.ready = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        chk("arst_no_done", done_seen, 0);
        run_job(3, 100, 2, 0, -1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
